pipe_fifo: RTL and testbench
============================

PIPE_FIFO -- requirements
Module: pipe_fifo

Interface
REQ-001 Parameter W_DATA, default 32, data word width in bits; legal range 1..64.
REQ-002 Parameter DEPTH, default 4, number of storage entries; SHALL be a power of two, 2..64.
REQ-003 Localparam W_CNT = clog2(DEPTH)+1, occupancy count width.
REQ-004 i_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset; SHALL be sampled only on the rising edge of i_clk.
REQ-006 s_valid  input  1  upstream word present.
REQ-007 s_ready  output  1  space available; registered; equals !full.
REQ-008 s_data  input  W_DATA  upstream word.
REQ-009 m_valid  output  1  word available to the downstream pipeline stage; registered; equals !empty.
REQ-010 m_ready  input  1  downstream accepts the word.
REQ-011 m_data  output  W_DATA  head-of-queue word; valid only while m_valid=1.
REQ-012 count  output  W_CNT  current occupancy, 0..DEPTH.
REQ-013 overflow  output  1  sticky flag: s_valid was asserted while s_ready=0.
REQ-014 underflow  output  1  sticky flag: m_ready was asserted while m_valid=0.
REQ-015 clr_err  input  1  clears both sticky flags.

Function
REQ-016 A push SHALL occur on a cycle where s_valid=1 and s_ready=1; a pop SHALL occur on a cycle where m_valid=1 and m_ready=1.
REQ-017 Read and write pointers SHALL each be clog2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0 without a gap.
REQ-018 On a push, s_data SHALL be written at the write pointer and the write pointer SHALL increment.
REQ-019 On a pop, the read pointer SHALL increment, and m_data SHALL present the next entry in the following cycle.
REQ-020 m_data SHALL be driven directly from storage at the read pointer; the first word pushed into an empty FIFO SHALL appear on m_data with m_valid=1 one cycle after the push.
REQ-021 Count update per cycle: push only -> +1; pop only -> -1; both or neither -> unchanged.
REQ-022 When full, a simultaneous push and pop SHALL NOT occur, because s_ready=0; the pop alone SHALL proceed, and s_ready SHALL be 1 in the next cycle.
REQ-023 When empty, a push SHALL NOT be popped in the same cycle; there is no bypass path.
REQ-024 s_valid while s_ready=0 SHALL leave storage, pointers and count unchanged and SHALL set overflow in the next cycle.
REQ-025 m_ready while m_valid=0 SHALL leave state unchanged and SHALL set underflow in the next cycle.
REQ-026 clr_err=1 SHALL clear both flags in the next cycle; if a new error occurs in the same cycle, the set SHALL take priority.
REQ-027 s_data and m_ready SHALL have no combinational path to any output.

Reset
REQ-028 While reset=1: pointers = 0, count = 0, m_valid = 0, s_ready = 0, overflow = 0, underflow = 0.
REQ-029 s_ready SHALL rise in the first cycle after reset deasserts.
REQ-030 Reset asserted mid-operation SHALL discard all stored words and SHALL take priority over a push or pop in the same cycle.
REQ-031 Storage contents SHALL NOT be reset; m_data is don't-care while m_valid=0.

Structure
REQ-032 A shared package SHALL hold the default W_DATA and DEPTH values and a clog2 constant function, so that the downstream stage and this block agree on widths.
REQ-033 Storage SHALL be a sub-module pipe_fifo_mem: DEPTH x W_DATA, one synchronous write port, one asynchronous read port, no reset.
REQ-034 Pointer, count, handshake and flag logic SHALL reside in pipe_fifo.

Verification
REQ-035 Reset, then push 0x11, 0x22, 0x33, 0x44 with m_ready=0 -> count=4, s_ready=0, m_valid=1, m_data=0x11.
REQ-036 Continue from REQ-035; pop 4 words -> m_data sequence 0x11, 0x22, 0x33, 0x44; count=0, m_valid=0, underflow=0.
REQ-037 Hold s_valid=1 and m_ready=1 for 20 cycles with an incrementing s_data -> count stays at 1, outputs are in order, the pointers wrap 5 times, and no flag is set.
REQ-038 Full FIFO, s_valid=1 with s_data=0xDEAD -> overflow=1 the next cycle; 0xDEAD never appears on m_data; clr_err -> overflow=0.
REQ-039 Empty FIFO with m_ready=1 -> underflow=1; clr_err asserted in the same cycle as a new underflow -> underflow stays 1.
REQ-040 Push 3 words, assert reset for 1 cycle during a push -> count=0, m_valid=0; s_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/pipe_fifo_pkg.sv
// Shared widths and helpers for pipe_fifo and its downstream consumers.
package pipe_fifo_pkg;

    localparam int unsigned PIPE_FIFO_W_DATA = 32;
    localparam int unsigned PIPE_FIFO_DEPTH  = 4;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v      = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pipe_fifo_mem.sv
// FIFO storage array: one synchronous write port, one asynchronous read port, no reset.
module pipe_fifo_mem
    import pipe_fifo_pkg::*;
#(
    parameter int unsigned W_DATA = PIPE_FIFO_W_DATA,
    parameter int unsigned DEPTH  = PIPE_FIFO_DEPTH,
    localparam int unsigned W_ADDR = clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [W_ADDR-1:0] i_waddr,
    input  logic [W_DATA-1:0] i_wdata,
    input  logic [W_ADDR-1:0] i_raddr,
    output logic [W_DATA-1:0] o_rdata
);

    logic [W_DATA-1:0] r_mem [DEPTH];

    // Write the addressed entry on an accepted push; contents are never cleared.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pipe_fifo.sv
// Registered-handshake FIFO between pipeline stages with sticky overflow/underflow flags.
module pipe_fifo
    import pipe_fifo_pkg::*;
#(
    parameter int unsigned W_DATA = PIPE_FIFO_W_DATA,
    parameter int unsigned DEPTH  = PIPE_FIFO_DEPTH,
    localparam int unsigned W_CNT = clog2(DEPTH) + 1
) (
    input  logic              i_clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [W_DATA-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [W_DATA-1:0] m_data,
    output logic [W_CNT-1:0]  count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    localparam int unsigned      W_PTR    = clog2(DEPTH);
    localparam logic [W_CNT-1:0] FULL_CNT = W_CNT'(DEPTH);

    logic [W_PTR-1:0] r_wptr;
    logic [W_PTR-1:0] r_rptr;
    logic [W_CNT-1:0] r_count;
    logic             r_s_ready;
    logic             r_m_valid;
    logic             r_overflow;
    logic             r_underflow;

    logic [W_CNT-1:0] w_count_nxt;
    logic             w_push;
    logic             w_pop;
    logic             w_ovf_evt;
    logic             w_unf_evt;
    logic             w_mem_we;

    // Handshake decode and next occupancy; both handshakes come from registered flags only.
    always_comb begin
        w_push      = s_valid & r_s_ready;
        w_pop       = m_ready & r_m_valid;
        w_ovf_evt   = s_valid & ~r_s_ready;
        w_unf_evt   = m_ready & ~r_m_valid;
        w_mem_we    = w_push & ~reset;
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // Pointers, count, registered ready/valid and sticky flags; reset wins over any transfer.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_s_ready   <= 1'b0;
            r_m_valid   <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count     <= w_count_nxt;
            r_s_ready   <= (w_count_nxt != FULL_CNT);
            r_m_valid   <= (w_count_nxt != '0);
            // A new error in the same cycle as clr_err keeps the flag set.
            r_overflow  <= w_ovf_evt | (r_overflow & ~clr_err);
            r_underflow <= w_unf_evt | (r_underflow & ~clr_err);
        end
    end

    pipe_fifo_mem #(
        .W_DATA (W_DATA),
        .DEPTH  (DEPTH)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_mem_we),
        .i_waddr (r_wptr),
        .i_wdata (s_data),
        .i_raddr (r_rptr),
        .o_rdata (m_data)
    );

    assign s_ready   = r_s_ready;
    assign m_valid   = r_m_valid;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_pipe_fifo.sv
// Scoreboard bench for pipe_fifo: directed scenarios followed by random traffic.
module tb_pipe_fifo;
    import pipe_fifo_pkg::*;

    localparam int unsigned W_DATA = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned W_CNT  = clog2(DEPTH) + 1;

    logic              i_clk = 1'b0;
    logic              reset = 1'b1;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [W_DATA-1:0] s_data = '0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [W_DATA-1:0] m_data;
    logic [W_CNT-1:0]  count;
    logic              overflow;
    logic              underflow;
    logic              clr_err = 1'b0;

    always #5 i_clk = ~i_clk;

    pipe_fifo #(
        .W_DATA (W_DATA),
        .DEPTH  (DEPTH)
    ) dut (
        .i_clk     (i_clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow),
        .clr_err   (clr_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Expected words in order; driver pushes on predicted accept, monitor pops on DUT pop.
    logic [W_DATA-1:0] sb[$];

    // Reference state: occupancy, ready flag (low during and just after reset), sticky flags.
    int m_cnt    = 0;
    bit m_sready = 1'b0;
    bit m_ovf    = 1'b0;
    bit m_unf    = 1'b0;

    bit chk_en = 1'b0;
    int exp_count;
    bit exp_sready, exp_mvalid, exp_ovf, exp_unf;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; also advances the reference model.
    task automatic step(input bit rst, input bit sv, input logic [W_DATA-1:0] sd,
                        input bit mr, input bit clr);
        bit push, pop;
        @(posedge i_clk);
        #1;
        exp_count  = m_cnt;
        exp_sready = m_sready;
        exp_mvalid = (m_cnt != 0);
        exp_ovf    = m_ovf;
        exp_unf    = m_unf;
        chk_en     = 1'b1;
        reset      = rst;
        s_valid    = sv;
        s_data     = sd;
        m_ready    = mr;
        clr_err    = clr;
        if (rst) begin
            m_cnt    = 0;
            m_sready = 1'b0;
            m_ovf    = 1'b0;
            m_unf    = 1'b0;
            sb.delete();
        end else begin
            push  = sv && m_sready;
            pop   = mr && (m_cnt != 0);
            m_ovf = (sv && !m_sready) || (m_ovf && !clr);
            m_unf = (mr && (m_cnt == 0)) || (m_unf && !clr);
            if (push) sb.push_back(sd);
            m_cnt    = m_cnt + int'(push) - int'(pop);
            m_sready = (m_cnt != DEPTH);
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    // Directed constant check against the state presented in the current cycle.
    task automatic expect_now(input string name, input logic [63:0] act_sel,
                              input logic [63:0] exp);
        check(name, act_sel, exp);
    endtask

    // Monitor: compare status every cycle, and the head word whenever one is presented.
    always @(negedge i_clk) begin
        if (chk_en) begin
            check("s_ready", 64'(s_ready), 64'(exp_sready));
            check("m_valid", 64'(m_valid), 64'(exp_mvalid));
            check("count", 64'(count), 64'(exp_count));
            check("overflow", 64'(overflow), 64'(exp_ovf));
            check("underflow", 64'(underflow), 64'(exp_unf));
            if (!reset && m_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL m_data: got 0x%0h with m_valid=1 expected no word", m_data);
                end else begin
                    check("m_data", 64'(m_data), 64'(sb[0]));
                    if (m_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        // Reset, then the one cycle where s_ready is still low.
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        idle();

        // Fill with four words, nothing popped.
        step(1'b0, 1'b1, 32'h11, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h22, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h33, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h44, 1'b0, 1'b0);
        idle();
        @(negedge i_clk);
        #1;
        expect_now("full_count", 64'(count), 64'd4);
        expect_now("full_s_ready", 64'(s_ready), 64'd0);
        expect_now("full_head", 64'(m_data), 64'h11);

        // Drain all four, then settle.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        idle();

        // Streaming with one word resident: pointers wrap several times.
        step(1'b0, 1'b1, 32'h100, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 32'h200 + 32'(i), 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        idle();

        // Overflow while full; the rejected word must never surface.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h500 + 32'(i), 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'hDEAD, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'hDEAD, 1'b0, 1'b0);
        idle();
        @(negedge i_clk);
        #1;
        expect_now("ovf_set", 64'(overflow), 64'd1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        idle();
        // Pop from full: the freed slot shows s_ready=1 next cycle.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        idle();

        // Underflow, then a clear colliding with a fresh underflow.
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        idle();
        @(negedge i_clk);
        #1;
        expect_now("unf_set_wins", 64'(underflow), 64'd1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        idle();

        // Reset during a push discards everything.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h700 + 32'(i), 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h7FF, 1'b1, 1'b0);
        idle();
        idle();
        @(negedge i_clk);
        #1;
        expect_now("post_rst_ready", 64'(s_ready), 64'd1);
        expect_now("post_rst_count", 64'(count), 64'd0);

        // Random traffic with occasional clears and resets.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 79) == 0), 1'($urandom_range(0, 2) != 0), $urandom(),
                 1'($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
        end
        idle();
        @(negedge i_clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
